// File: rtl/memory_arbiter.sv
// Multi-channel write buffer: one FIFO per producer, round-robin drain into a single memory port.
// Optional sticky drop flags are built when MEM_ARB_OVERFLOW_EN is defined.
module memory_arbiter #(
    parameter int N     = 32,
    parameter int CH    = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CH-1:0]          store,
    input  logic [CH*N-1:0]        data,
    input  logic                   mem_ready,
    output logic                   write,
    output logic [$clog2(CH)-1:0]  sel,
    output logic [N-1:0]           wdata,
    output logic [CH-1:0]          full,
    output logic [CH-1:0]          overflow
);

    localparam int SW = $clog2(CH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  mem    [CH][DEPTH];
    logic [PW-1:0] rd_ptr [CH];
    logic [PW-1:0] wr_ptr [CH];
    logic [CW-1:0] count  [CH];
    logic [SW-1:0] last;

    logic          gnt_valid;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] cand;
    logic [CH-1:0] push_ok;
    logic [CH-1:0] pop_ch;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            full[i] = (count[i] == CW'(DEPTH));
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= CH; k++) begin
            cand = SW'((int'(last) + k) % CH);
            if (!gnt_valid && mem_ready && count[cand] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // A full channel drops its push even if it is being popped on the same edge.
    always_comb begin
        push_ok = '0;
        pop_ch  = '0;
        for (int i = 0; i < CH; i++) begin
            push_ok[i] = store[i] && !full[i];
            pop_ch[i]  = gnt_valid && (gnt_idx == SW'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i]] <= data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop_ch[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(push_ok[i]) - CW'(pop_ch[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last  <= SW'(CH - 1);
            write <= 1'b0;
            sel   <= '0;
            wdata <= '0;
        end else if (gnt_valid) begin
            last  <= gnt_idx;
            write <= 1'b1;
            sel   <= gnt_idx;
            wdata <= mem[gnt_idx][rd_ptr[gnt_idx]];
        end else begin
            write <= 1'b0;
        end
    end

`ifdef MEM_ARB_OVERFLOW_EN
    logic [CH-1:0] overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_q | (store & full);
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a queue-based reference model.
module tb_memory_arbiter;

    localparam int N     = 32;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(CH);

    logic              clk;
    logic              reset;
    logic [CH-1:0]     store;
    logic [CH*N-1:0]   data;
    logic              mem_ready;
    logic              write;
    logic [SW-1:0]     sel;
    logic [N-1:0]      wdata;
    logic [CH-1:0]     full;
    logic [CH-1:0]     overflow;

    int total = 0;
    int bad   = 0;

    typedef logic [N-1:0] word_t;
    word_t q [CH][$];
    int          m_last;
    logic        exp_write;
    logic [SW-1:0] exp_sel;
    logic [N-1:0]  exp_wdata;
    logic [CH-1:0] exp_full;
    logic [CH-1:0] exp_ovf;

    memory_arbiter #(.N(N), .CH(CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .store(store), .data(data), .mem_ready(mem_ready),
        .write(write), .sel(sel), .wdata(wdata), .full(full), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < CH; i++) q[i].delete();
        m_last    = CH - 1;
        exp_write = 1'b0;
        exp_sel   = '0;
        exp_wdata = '0;
        exp_full  = '0;
        exp_ovf   = '0;
    endtask

    // One clock edge of the reference: arbitration and fullness use pre-edge queue sizes.
    task automatic model_edge();
        bit [CH-1:0] was_full;
        int g;
        int c;
        g = -1;
        for (int i = 0; i < CH; i++) was_full[i] = (q[i].size() == DEPTH);
        if (mem_ready) begin
            for (int k = 1; k <= CH; k++) begin
                c = (m_last + k) % CH;
                if (g < 0 && q[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            exp_write = 1'b1;
            exp_sel   = g[SW-1:0];
            exp_wdata = q[g].pop_front();
            m_last    = g;
        end else begin
            exp_write = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin
            if (store[i]) begin
                if (was_full[i]) begin
`ifdef MEM_ARB_OVERFLOW_EN
                    exp_ovf[i] = 1'b1;
`endif
                end else begin
                    q[i].push_back(data[i*N +: N]);
                end
            end
        end
        for (int i = 0; i < CH; i++) exp_full[i] = (q[i].size() == DEPTH);
    endtask

    task automatic cycle(input logic [CH-1:0] st, input logic [CH*N-1:0] d, input logic rdy);
        store     = st;
        data      = d;
        mem_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        store = '0;
        mem_ready = 1'b0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        store = '0;
        data = '0;
        mem_ready = 1'b0;
        model_reset();
        #3;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", write); end
        total++; if (sel !== '0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        total++; if (wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        total++; if (full !== '0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== '0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [CH*N-1:0] d;
        do_reset();
        d = '0;
        d[1*N +: N] = 32'hA5A5A5A5;
        cycle(4'b0010, d, 1'b1);
        total++; if (write !== 1'b0) begin bad++; $display("FAIL single_e1 write got=%b exp=0", write); end
        cycle('0, '0, 1'b1);
        total++; if ({write, sel, wdata} !== {1'b1, 2'd1, 32'hA5A5A5A5})
            begin bad++; $display("FAIL single_e2 got w=%b s=%0d d=%h exp w=1 s=1 d=a5a5a5a5", write, sel, wdata); end
        cycle('0, '0, 1'b1);
        total++; if (write !== 1'b0) begin bad++; $display("FAIL single_e3 write got=%b exp=0", write); end
    endtask

    task automatic test_all_channels();
        logic [CH*N-1:0] d;
        do_reset();
        for (int i = 0; i < CH; i++) d[i*N +: N] = 32'h10 + i;
        cycle('1, d, 1'b1);
        for (int k = 0; k < CH; k++) begin
            cycle('0, '0, 1'b1);
            total++; if ({write, sel, wdata} !== {1'b1, k[SW-1:0], 32'h10 + k})
                begin bad++; $display("FAIL allch_%0d got w=%b s=%0d d=%h exp w=1 s=%0d d=%h", k, write, sel, wdata, k, 32'h10 + k); end
        end
        cycle('0, '0, 1'b1);
        total++; if (write !== 1'b0) begin bad++; $display("FAIL allch_idle write got=%b exp=0", write); end
    endtask

    task automatic test_overflow();
        logic [CH*N-1:0] d;
        logic [CH-1:0] ovf_req;
        do_reset();
        for (int w = 1; w <= 6; w++) begin
            d = '0;
            d[2*N +: N] = w;
            cycle(4'b0100, d, 1'b0);
            total++; if (full[2] !== (w >= 4)) begin bad++; $display("FAIL ovf_full push=%0d got=%b exp=%b", w, full[2], (w >= 4)); end
        end
`ifdef MEM_ARB_OVERFLOW_EN
        ovf_req = 4'b0100;
`else
        ovf_req = 4'b0000;
`endif
        total++; if (overflow !== ovf_req) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ovf_req); end
        for (int w = 1; w <= 5; w++) begin
            cycle('0, '0, 1'b1);
            total++; if ({write, wdata} !== {(w <= 4), (w <= 4) ? 32'(w) : 32'd4})
                begin bad++; $display("FAIL ovf_drain_%0d got w=%b d=%h exp w=%b", w, write, wdata, (w <= 4)); end
        end
    endtask

    task automatic test_rotation();
        logic [CH*N-1:0] d;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            d = {CH{$urandom()}};
            cycle(4'b1001, d, !(c == 6 || c == 7));
            total++; if ({write, sel, wdata} !== {exp_write, exp_sel, exp_wdata})
                begin bad++; $display("FAIL rot_%0d got w=%b s=%0d d=%h exp w=%b s=%0d d=%h", c, write, sel, wdata, exp_write, exp_sel, exp_wdata); end
            if (c >= 1 && c <= 4) begin
                total++; if (sel !== ((c % 2 == 1) ? 2'd0 : 2'd3))
                    begin bad++; $display("FAIL rot_alt_%0d got=%0d exp=%0d", c, sel, (c % 2 == 1) ? 0 : 3); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [CH*N-1:0] d;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            d = '0;
            d[0 +: N] = 32'hC0 + w;
            cycle(4'b0001, d, 1'b0);
        end
        cycle('0, '0, 1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++; if ({write, sel, wdata, full, overflow} !== '0)
            begin bad++; $display("FAIL midrst_async got w=%b s=%0d d=%h f=%b o=%b exp all zero", write, sel, wdata, full, overflow); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle('0, '0, 1'b1);
            total++; if (write !== 1'b0) begin bad++; $display("FAIL midrst_idle_%0d write got=%b exp=0", c, write); end
        end
    endtask

    task automatic test_random();
        logic [CH*N-1:0] d;
        logic [CH-1:0] st;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < CH; i++) d[i*N +: N] = $urandom();
            st = CH'($urandom());
            cycle(st, d, ($urandom_range(0, 3) != 0));
            total++; if ({write, sel, wdata} !== {exp_write, exp_sel, exp_wdata})
                begin bad++; $display("FAIL rand_out_%0d got w=%b s=%0d d=%h exp w=%b s=%0d d=%h", c, write, sel, wdata, exp_write, exp_sel, exp_wdata); end
            total++; if ({full, overflow} !== {exp_full, exp_ovf})
                begin bad++; $display("FAIL rand_flags_%0d got f=%b o=%b exp f=%b o=%b", c, full, overflow, exp_full, exp_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_overflow();
        test_rotation();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
